// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [7:0] ERR_CHAR_DEFAULT = 8'h3F;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef struct packed {
    logic parity_bit;
    logic parity_err;
    logic frame_err;
  } rx_flags_t;

  // Parity bit a correct transmitter would send for this word (zero-extended data).
  function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] data,
                                           input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

  function automatic logic parity_error(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic parity_bit,
                                        input logic [1:0] mode);
    return (mode != PAR_NONE) && (parity_bit != expected_parity(data, mode));
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning: 2-FF synchroniser plus 3-sample majority vote, idle-high reset.
module uart_rx_sampler (
  input  logic clk_3125,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic vote_c
);

  logic       sync1;
  logic [1:0] hist;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      hist  <= 2'b11;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      hist  <= {hist[0], rx_s};
    end
  end

  // Majority over the current and two previous synchronised samples.
  assign vote_c = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit voted sampling, error flags, valid/ready delivery.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 27,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned ERR_SUBST    = 1,
  parameter logic [7:0]  ERR_CHAR     = ERR_CHAR_DEFAULT
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_bit,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] PMODE  = 2'(PARITY_MODE);
  localparam bit         PAR_EN = (PMODE == PAR_EVEN) || (PMODE == PAR_ODD);

  localparam logic [DATA_BITS-1:0] ERR_WORD   = DATA_BITS'(ERR_CHAR);
  localparam logic [CNT_W-1:0]     START_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]     BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]     STOP_LAST  = IDX_W'(STOP_BITS - 1);

  logic rx_s;
  logic vote_c;

  uart_rx_sampler u_sampler (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_s     (rx_s),
    .vote_c   (vote_c)
  );

  uart_rx_state_t       state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic                 par_q, par_n;
  logic                 ferr_q, ferr_n;
  logic                 done_q, done_n;
  logic [DATA_BITS-1:0] word_q, word_n;
  rx_flags_t            flags_q, flags_n;

  logic bit_tick_c;
  logic frame_err_c;
  logic parity_err_c;

  assign bit_tick_c   = (cnt_q == BIT_LAST);
  assign frame_err_c  = ferr_q | ~vote_c;
  assign parity_err_c = parity_error(MAX_DATA_BITS'(shreg_q), par_q, PMODE);

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      flags_q <= '0;
      rx_busy <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shreg_q <= shreg_n;
      par_q   <= par_n;
      ferr_q  <= ferr_n;
      done_q  <= done_n;
      word_q  <= word_n;
      flags_q <= flags_n;
      rx_busy <= (state_n != ST_IDLE);
    end
  end

  // Frame sequencing; the completed word is staged in word_q/flags_q for one cycle.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    ferr_n  = ferr_q;
    done_n  = 1'b0;
    word_n  = word_q;
    flags_n = flags_q;

    case (state_q)
      ST_IDLE: begin
        cnt_n  = '0;
        ferr_n = 1'b0;
        par_n  = 1'b0;
        if (!rx_s) state_n = ST_START;
      end

      ST_START: begin
        if (cnt_q == START_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = vote_c ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_tick_c) begin
          cnt_n   = '0;
          shreg_n = (MSB_FIRST != 0) ? {shreg_q[DATA_BITS-2:0], vote_c}
                                     : {vote_c, shreg_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_n   = '0;
            state_n = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (bit_tick_c) begin
          cnt_n   = '0;
          idx_n   = '0;
          par_n   = vote_c;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_tick_c) begin
          cnt_n  = '0;
          ferr_n = frame_err_c;
          if (idx_q == STOP_LAST) begin
            idx_n              = '0;
            done_n             = 1'b1;
            word_n             = ((ERR_SUBST != 0) && (parity_err_c || frame_err_c))
                                 ? ERR_WORD : shreg_q;
            flags_n.parity_bit = par_q;
            flags_n.parity_err = parity_err_c;
            flags_n.frame_err  = frame_err_c;
            // A low stop bit may be a break; wait for the line to recover first.
            state_n            = frame_err_c ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Output register: load when free or being handshaken, otherwise drop and flag overrun.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_bit <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (done_q && (!rx_valid || rx_ready)) begin
        rx_data       <= word_q;
        rx_valid      <= 1'b1;
        rx_parity_bit <= flags_q.parity_bit;
        rx_parity_err <= flags_q.parity_err;
        rx_frame_err  <= flags_q.frame_err;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (done_q && rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + randomized bench for uart_rx_param against a frame-level reference model.
module tb_uart_rx_param;

  localparam int unsigned CPB  = 8;
  localparam int unsigned HALF = CPB / 2;

  typedef struct {
    logic [8:0]  data;
    logic        pbit;
    logic        perr;
    logic        ferr;
    int unsigned t;
  } obs_t;

  typedef struct {
    logic [8:0] data;
    logic       pbit;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk_3125 = 1'b0;
  logic rst_n, rx_ab, rx2, ready_ab, ready2;

  logic [7:0] a_data, b_data;
  logic [6:0] c_data;
  logic a_valid, a_pbit, a_perr, a_ferr, a_ovr, a_busy;
  logic b_valid, b_pbit, b_perr, b_ferr, b_ovr, b_busy;
  logic c_valid, c_pbit, c_perr, c_ferr, c_ovr, c_busy;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  obs_t qa[$], qb[$], qc[$];

  always #5 clk_3125 = ~clk_3125;
  always @(posedge clk_3125) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk_3125(clk_3125), .rst_n(rst_n), .rx(rx_ab), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(ready_ab), .rx_parity_bit(a_pbit), .rx_parity_err(a_perr),
    .rx_frame_err(a_ferr), .rx_overrun(a_ovr), .rx_busy(a_busy));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .ERR_SUBST(0)) dut_b (
    .clk_3125(clk_3125), .rst_n(rst_n), .rx(rx_ab), .rx_data(b_data), .rx_valid(b_valid),
    .rx_ready(ready_ab), .rx_parity_bit(b_pbit), .rx_parity_err(b_perr),
    .rx_frame_err(b_ferr), .rx_overrun(b_ovr), .rx_busy(b_busy));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2),
                  .MSB_FIRST(0)) dut_c (
    .clk_3125(clk_3125), .rst_n(rst_n), .rx(rx2), .rx_data(c_data), .rx_valid(c_valid),
    .rx_ready(ready2), .rx_parity_bit(c_pbit), .rx_parity_err(c_perr),
    .rx_frame_err(c_ferr), .rx_overrun(c_ovr), .rx_busy(c_busy));

  function automatic obs_t mk(input logic [8:0] d, input logic p, input logic pe,
                              input logic fe, input int unsigned t);
    obs_t o;
    o.data = d; o.pbit = p; o.perr = pe; o.ferr = fe; o.t = t;
    return o;
  endfunction

  // Record every handshake seen at each consumer.
  always @(negedge clk_3125) begin
    if (a_valid && ready_ab) qa.push_back(mk(9'(a_data), a_pbit, a_perr, a_ferr, cyc));
    if (b_valid && ready_ab) qb.push_back(mk(9'(b_data), b_pbit, b_perr, b_ferr, cyc));
    if (c_valid && ready2)   qc.push_back(mk(9'(c_data), c_pbit, c_perr, c_ferr, cyc));
  end

  // Reference: what a receiver should present for a frame built from these choices.
  function automatic exp_t model(input logic [8:0] word, input int dbits, input int pmode,
                                 input bit pflip, input bit stop0, input bit subst);
    exp_t e;
    logic [8:0] mask;
    int ones;
    bit req;
    mask   = 9'h1FF >> (9 - dbits);
    ones   = $countones(word & mask);
    req    = (pmode == 2) ? (ones % 2 == 0) : (ones % 2 == 1);
    e.pbit = (pmode == 0) ? 1'b0 : (req ^ pflip);
    e.perr = (pmode != 0) && (e.pbit != req);
    e.ferr = stop0;
    e.data = (subst && (e.perr || e.ferr)) ? (9'h03F & mask) : (word & mask);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_3125);
      #1;
    end
  endtask

  task automatic drive(input bit line, input bit v);
    if (line) rx2 = v;
    else      rx_ab = v;
  endtask

  task automatic send(input bit line, input logic [8:0] word, input int dbits, input bit msb,
                      input int pmode, input bit pflip, input int nstop, input bit stop0,
                      input int glitch);
    bit   bits[$];
    exp_t e;
    e = model(word, dbits, pmode, pflip, stop0, 1'b0);
    bits.push_back(1'b0);
    for (int i = 0; i < dbits; i++) bits.push_back(word[msb ? dbits - 1 - i : i]);
    if (pmode != 0) bits.push_back(e.pbit);
    for (int s = 0; s < nstop; s++) bits.push_back(!(stop0 && s == 0));
    for (int k = 0; k < bits.size(); k++) begin
      drive(line, bits[k]);
      if (k == 0) t0 = cyc;
      if (k == glitch) begin
        tick(4);
        drive(line, !bits[k]);
        tick(1);
        drive(line, bits[k]);
        tick(CPB - 5);
      end else begin
        tick(CPB);
      end
    end
  endtask

  task automatic expect_word(input int which, input string tag, input exp_t e, output obs_t o);
    int n;
    n = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
    o = mk(9'h0, 1'b0, 1'b0, 1'b0, 0);
    chk({tag, "_present"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      case (which)
        0:       o = qa.pop_front();
        1:       o = qb.pop_front();
        default: o = qc.pop_front();
      endcase
      chk({tag, "_data"}, 32'(o.data), 32'(e.data));
      chk({tag, "_pbit"}, 32'(o.pbit), 32'(e.pbit));
      chk({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
      chk({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    exp_t e;
    logic [8:0] w;
    bit f;
    int lat;

    rst_n = 1'b0; rx_ab = 1'b1; rx2 = 1'b1; ready_ab = 1'b1; ready2 = 1'b1;
    tick(3);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_data",  32'(a_data), 0);
    chk("rst_busy",  32'(a_busy | b_busy | c_busy), 0);
    chk("rst_ovr",   32'(a_ovr), 0);
    rst_n = 1'b1;
    tick(5);

    // Clean 0xA5 even parity, plus latency
    send(0, 9'hA5, 8, 1, 1, 0, 1, 0, -1);
    tick(6);
    expect_word(0, "a5_a", model(9'hA5, 8, 1, 0, 0, 1), o);
    lat = int'(o.t) - int'(t0);
    chk("a5_latency", 32'(lat >= 2 + 1 + HALF + 10 * CPB && lat <= 2 + 1 + HALF + 10 * CPB + 2), 1);
    chk("a5_one_pulse", 32'(qa.size()), 0);
    expect_word(1, "a5_b", model(9'hA5, 8, 1, 0, 0, 0), o);

    // Wrong parity bit: substituted vs raw
    send(0, 9'hA5, 8, 1, 1, 1, 1, 0, -1);
    tick(6);
    expect_word(0, "perr_a", model(9'hA5, 8, 1, 1, 0, 1), o);
    expect_word(1, "perr_b", model(9'hA5, 8, 1, 1, 0, 0), o);

    // Two-cycle low glitch: false start rejected
    rx_ab = 1'b0;
    tick(2);
    rx_ab = 1'b1;
    tick(2);
    chk("glitch_busy_hi", 32'(a_busy), 1);
    tick(HALF + 2);
    chk("glitch_busy_lo", 32'(a_busy), 0);
    tick(20);
    chk("glitch_no_word", 32'(qa.size() + qb.size()), 0);

    // One-cycle high spike inside a zero data bit
    send(0, 9'h000, 8, 1, 1, 0, 1, 0, 3);
    tick(6);
    expect_word(0, "spike", model(9'h000, 8, 1, 0, 0, 1), o);
    qb.delete();

    // Randomized words through both 8-bit receivers
    for (int r = 0; r < 6; r++) begin
      w = 9'($urandom_range(0, 255));
      f = ($urandom_range(0, 3) == 0);
      send(0, w, 8, 1, 1, f, 1, 0, -1);
      tick(4);
      expect_word(0, "rand_a", model(w, 8, 1, f, 0, 1), o);
      expect_word(1, "rand_b", model(w, 8, 1, f, 0, 0), o);
    end

    // Overrun: consumer stalled across two frames
    ready_ab = 1'b0;
    send(0, 9'h11, 8, 1, 1, 0, 1, 0, -1);
    send(0, 9'h22, 8, 1, 1, 0, 1, 0, -1);
    tick(6);
    chk("ovr_valid", 32'(a_valid), 1);
    chk("ovr_data",  32'(a_data), 32'h11);
    chk("ovr_flag",  32'(a_ovr), 1);
    ready_ab = 1'b1;
    tick(1);
    ready_ab = 1'b0;
    chk("ovr_hs_valid", 32'(a_valid), 0);
    chk("ovr_hs_flag",  32'(a_ovr), 0);
    expect_word(0, "ovr_word", model(9'h11, 8, 1, 0, 0, 1), o);
    qb.delete();
    ready_ab = 1'b1;
    tick(4);

    // Stop bit low followed by a long break
    send(0, 9'h5A, 8, 1, 1, 0, 1, 1, -1);
    rx_ab = 1'b0;
    tick(20);
    chk("brk_busy", 32'(a_busy), 1);
    tick(20);
    rx_ab = 1'b1;
    tick(20);
    chk("brk_count", 32'(qa.size()), 1);
    expect_word(0, "brk_a", model(9'h5A, 8, 1, 0, 1, 1), o);
    expect_word(1, "brk_b", model(9'h5A, 8, 1, 0, 1, 0), o);

    // 7 data bits, odd parity, 2 stops, LSB first, back-to-back
    send(1, 9'h35, 7, 0, 2, 0, 2, 0, -1);
    send(1, 9'h35, 7, 0, 2, 0, 2, 0, -1);
    tick(4);
    e = model(9'h35, 7, 2, 0, 0, 1);
    expect_word(2, "b2b_1", e, o);
    expect_word(2, "b2b_2", e, o);

    // Reset in the middle of a third frame
    rx2 = 1'b0;
    tick(CPB);
    rx2 = 1'b1;
    tick(2 * CPB);
    chk("mid_busy", 32'(c_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({c_valid, c_data, c_pbit, c_perr, c_ferr, c_ovr, c_busy}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(100);
    chk("mid_no_word", 32'(qc.size()), 0);
    chk("mid_valid", 32'(c_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
